// File: rtl/pipe_ctrl_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ctrl_pkg
// Description : Opcode constants and ex_ctrl bundle bit positions shared by
//               the pipelined control decoder, its interface and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Width of the control bundle carried into EX
  localparam int CTRL_W = 15;

  // Bit positions inside the control bundle (MSB first)
  localparam int CB_MEMTOREG = 14;
  localparam int CB_MEMWRITE = 13;
  localparam int CB_ALU_SRC  = 12;
  localparam int CB_REGWRITE = 11;
  localparam int CB_ECALL    = 10;
  localparam int CB_S_TYPE   = 9;
  localparam int CB_BEQ      = 8;
  localparam int CB_BNE      = 7;
  localparam int CB_JALR     = 6;
  localparam int CB_JAL      = 5;
  localparam int CB_LUI      = 4;
  localparam int CB_LBU      = 3;
  localparam int CB_BLTU     = 2;
  localparam int CB_STI      = 1;
  localparam int CB_CLI      = 0;

  // instr[6:2] major opcodes
  localparam logic [4:0] OP_LOAD   = 5'h00;
  localparam logic [4:0] OP_IMM    = 5'h04;
  localparam logic [4:0] OP_STORE  = 5'h08;
  localparam logic [4:0] OP_REG    = 5'h0C;
  localparam logic [4:0] OP_LUI    = 5'h0D;
  localparam logic [4:0] OP_BRANCH = 5'h18;
  localparam logic [4:0] OP_JALR   = 5'h19;
  localparam logic [4:0] OP_JAL    = 5'h1B;
  localparam logic [4:0] OP_SYSTEM = 5'h1C;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : pipe_ctrl_decoder_if
// Description : ID-side request, hazard controls and ID/EX outputs of the
//               pipelined control decoder. RV32M_EN adds ex_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_decoder_if;
  import ctrl_pkg::*;

  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [4:0]  id_funct;
  logic        stall;
  logic        flush;
  logic        id_ready;
  logic        ex_valid;
  ctrl_t       ex_ctrl;
  logic        ex_illegal;
  logic        ie;
  logic        halt;
`ifdef RV32M_EN
  logic        ex_muldiv;
`endif

  // ID stage / hazard unit side
  modport master (
    output id_valid, id_opcode, id_funct, stall, flush,
    input  id_ready, ex_valid, ex_ctrl, ex_illegal, ie, halt
`ifdef RV32M_EN
    , input ex_muldiv
`endif
  );

  // Decoder side
  modport slave (
    input  id_valid, id_opcode, id_funct, stall, flush,
    output id_ready, ex_valid, ex_ctrl, ex_illegal, ie, halt
`ifdef RV32M_EN
    , output ex_muldiv
`endif
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_decoder_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_comb
// Description : Pure combinational opcode/funct to control bundle decode with
//               illegal-encoding detection. RV32M_EN adds MUL/DIV decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  wire logic [4:0] i_opcode,
  input  wire logic [4:0] i_funct,
  output ctrl_t           o_ctrl,
`ifdef RV32M_EN
  output logic            o_muldiv,
`endif
  output logic            o_illegal
);

  logic [2:0] w_f3;
  logic [1:0] w_f43;
  logic       w_imm_ok;

  assign w_f3  = i_funct[2:0];
  assign w_f43 = i_funct[4:3];

  // Illegal encodings always leave the bundle all-zero
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    w_imm_ok  = 1'b0;
`ifdef RV32M_EN
    o_muldiv  = 1'b0;
`endif
    case (i_opcode)
      OP_LOAD: begin
        if (w_f3 == 3'b010 || w_f3 == 3'b100) begin
          o_ctrl[CB_MEMTOREG] = 1'b1;
          o_ctrl[CB_ALU_SRC]  = 1'b1;
          o_ctrl[CB_REGWRITE] = 1'b1;
          o_ctrl[CB_LBU]      = (w_f3 == 3'b100);
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_f3 == 3'b010) begin
          o_ctrl[CB_MEMWRITE] = 1'b1;
          o_ctrl[CB_ALU_SRC]  = 1'b1;
          o_ctrl[CB_S_TYPE]   = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        // f[4:3] are immediate bits except for the shift-immediate forms
        case (w_f3)
          3'b000, 3'b010, 3'b100, 3'b110, 3'b111: w_imm_ok = 1'b1;
          3'b001:  w_imm_ok = (w_f43 == 2'b00);
          3'b101:  w_imm_ok = (w_f43 == 2'b00) || (w_f43 == 2'b10);
          default: w_imm_ok = 1'b0;
        endcase
        if (w_imm_ok) begin
          o_ctrl[CB_ALU_SRC]  = 1'b1;
          o_ctrl[CB_REGWRITE] = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_REG: begin
        case (i_funct)
          5'b00000, 5'b10000, 5'b00111, 5'b00110,
          5'b00010, 5'b00011, 5'b00101: o_ctrl[CB_REGWRITE] = 1'b1;
`ifdef RV32M_EN
          5'b01000, 5'b01100: begin
            o_ctrl[CB_REGWRITE] = 1'b1;
            o_muldiv            = 1'b1;
          end
`endif
          default: o_illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (w_f3)
          3'b000:  o_ctrl[CB_BEQ]  = 1'b1;
          3'b001:  o_ctrl[CB_BNE]  = 1'b1;
          3'b110:  o_ctrl[CB_BLTU] = 1'b1;
          default: o_illegal       = 1'b1;
        endcase
      end
      OP_JALR: begin
        if (w_f3 == 3'b000) begin
          o_ctrl[CB_JALR]     = 1'b1;
          o_ctrl[CB_ALU_SRC]  = 1'b1;
          o_ctrl[CB_REGWRITE] = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_JAL: begin
        o_ctrl[CB_JAL]      = 1'b1;
        o_ctrl[CB_REGWRITE] = 1'b1;
      end
      OP_LUI: begin
        o_ctrl[CB_LUI]      = 1'b1;
        o_ctrl[CB_REGWRITE] = 1'b1;
      end
      OP_SYSTEM: begin
        if (i_funct == 5'b00000) begin
          o_ctrl[CB_ECALL] = 1'b1;
        end else if (w_f3 == 3'b110) begin
          o_ctrl[CB_STI]     = 1'b1;
          o_ctrl[CB_ALU_SRC] = 1'b1;
        end else if (w_f3 == 3'b111) begin
          o_ctrl[CB_CLI]     = 1'b1;
          o_ctrl[CB_ALU_SRC] = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_decoder
// Description : ID/EX control register for the pipelined core: decodes the ID
//               instruction, applies flush > stall > load, keeps the sticky
//               interrupt-enable and ecall-halt flags.
//               Optional macro RV32M_EN: MUL/DIV decode plus ex_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit IE_RESET       = 1'b0,
  parameter bit HALT_ON_ECALL  = 1'b1,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input wire logic           clk,
  input wire logic           rst,
  pipe_ctrl_decoder_if.slave bus
);

  ctrl_t w_ctrl;
  logic  w_illegal;
  logic  w_take;
  logic  w_load;
  logic  w_nxt_valid;
  ctrl_t w_nxt_ctrl;
  logic  w_nxt_illegal;

  ctrl_t r_ex_ctrl;
  logic  r_ex_valid;
  logic  r_ex_illegal;
  logic  r_ie;
  logic  r_halt;
`ifdef RV32M_EN
  logic  w_muldiv;
  logic  r_ex_muldiv;
`endif

  ctrl_decode_comb u_decode (
    .i_opcode  (bus.id_opcode),
    .i_funct   (bus.id_funct),
    .o_ctrl    (w_ctrl),
`ifdef RV32M_EN
    .o_muldiv  (w_muldiv),
`endif
    .o_illegal (w_illegal)
  );

  // An instruction only enters EX while not halted; a halted ID yields bubbles
  assign w_take = bus.id_valid && !r_halt;
  assign w_load = !bus.flush && !bus.stall;

  // Compose the entry that a load cycle would write into ID/EX
  always_comb begin
    w_nxt_ctrl    = w_take ? w_ctrl : '0;
    w_nxt_illegal = bus.id_valid && w_illegal;
    if (ILLEGAL_AS_NOP) begin
      w_nxt_valid = w_take && !w_illegal;
    end else begin
      w_nxt_valid = w_take;
    end
  end

  // ID/EX entry registers: flush squashes, stall holds, otherwise load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= '0;
      r_ex_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= '0;
      r_ex_illegal <= 1'b0;
    end else if (!bus.stall) begin
      r_ex_valid   <= w_nxt_valid;
      r_ex_ctrl    <= w_nxt_ctrl;
      r_ex_illegal <= w_nxt_illegal;
    end
  end

`ifdef RV32M_EN
  // Multiply/divide marker follows the same flush/stall/load rules
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_muldiv <= 1'b0;
    end else if (bus.flush) begin
      r_ex_muldiv <= 1'b0;
    end else if (!bus.stall) begin
      r_ex_muldiv <= w_take && w_muldiv;
    end
  end
  assign bus.ex_muldiv = r_ex_muldiv;
`endif

  // Interrupt enable changes only when a legal STI/CLI actually enters EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie <= IE_RESET;
    end else if (w_load && w_take) begin
      if (w_ctrl[CB_STI]) begin
        r_ie <= 1'b1;
      end else if (w_ctrl[CB_CLI]) begin
        r_ie <= 1'b0;
      end
    end
  end

  // Sticky halt on an ecall entering EX; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt <= 1'b0;
    end else if (HALT_ON_ECALL && w_load && w_take && w_ctrl[CB_ECALL]) begin
      r_halt <= 1'b1;
    end
  end

  assign bus.id_ready   = !bus.stall && !r_halt;
  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_ctrl    = r_ex_ctrl;
  assign bus.ex_illegal = r_ex_illegal;
  assign bus.ie         = r_ie;
  assign bus.halt       = r_halt;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_decoder.md
Name: pipe_ctrl_decoder

Overview:
- Successor of the single-cycle control signal decoder for the pipelined core: decodes RV32I subset plus custom STI/CLI and ecall into a control bundle, registered into the ID/EX stage.
- Adds a valid/stall/flush handshake, a sticky interrupt-enable flag, a sticky ecall halt, and illegal-instruction detection.
- Sits between the IF/ID register and the EX stage. Hazard unit drives stall/flush.

Parameters:
- IE_RESET, 0, reset value of the interrupt-enable flag.
- HALT_ON_ECALL, 1, 1 = ecall sets sticky halt; 0 = ecall only pulses ex_ecall.
- ILLEGAL_AS_NOP, 1, 1 = illegal encodings enter EX as a bubble with ex_illegal=1; 0 = they are decoded to all-zero controls with ex_valid=1.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds an instruction.
- id_opcode  in  5  instr[6:2].
- id_funct  in  5  {instr[30], instr[25], instr[14:12]}.
- stall  in  1  hold ID/EX contents.
- flush  in  1  squash the ID/EX entry.
- id_ready  out  1  ID may advance; equals !stall && !halt.
- ex_valid  out  1  EX entry valid.
- ex_ctrl  out  15  {MemToReg, MemWrite, ALU_SRC, RegWrite, ecall, S_type, Beq, Bne, Jalr, JAL, LUI, LBU, Bltu, STI, CLI}.
- ex_illegal  out  1  EX entry came from an undecodable encoding.
- ie  out  1  interrupt-enable state.
- halt  out  1  sticky ecall halt.

Behaviour:
- Reset (async): ex_valid=0, ex_ctrl=0, ex_illegal=0, ie=IE_RESET, halt=0.
- Decode is combinational; results register on rising clk. Latency is 1 cycle from ID to EX outputs.
- Decode table:
  - 0x00: lw (f[2:0]=010) and lbu (100); lbu also sets LBU.
  - 0x08: sw (010).
  - 0x04: ADDI/ANDI/ORI/XORI/SLTI for any f[4:3]. SLLI with f[4:3]=00. SRLI with 00, SRAI with 10.
  - 0x0C: ADD (00000), SUB (10000), AND, OR, SLT, SLTU, SRL.
  - 0x18: beq/bne/bltu.
  - 0x19: jalr (000).
  - 0x1B: jal.
  - 0x0D: lui.
  - 0x1C: f=00000 is ecall; f[2:0]=110 is STI; f[2:0]=111 is CLI. Both STI and CLI set ALU_SRC.
  - Any other combination is illegal.
- Update priority per cycle: flush > stall > load.
  - flush: ex_valid=0, ex_ctrl=0, ex_illegal=0.
  - stall without flush: all EX registers hold.
  - Otherwise load: ex_valid=id_valid && !halt, with the bundle loaded. An illegal encoding with ILLEGAL_AS_NOP=1 loads ex_ctrl=0, ex_valid=0, ex_illegal=id_valid.
- ie changes only on a load cycle with a valid legal STI (ie←1) or CLI (ie←0). STI/CLI squashed by flush, or held by stall, have no effect.
- halt sets on a load cycle with a valid ecall when HALT_ON_ECALL=1. Cleared only by rst.
  - While halt=1, id_ready=0 and subsequent loads insert bubbles.
  - The ecall entry itself stays visible in EX for one cycle.
- Simultaneous stall and flush: flush wins.
- rst asserted mid-stall clears everything immediately.

Optional Feature:
- Macro RV32M_EN.
- Defined: opcode 0x0C with f=01000 (MUL) and 01100 (DIV) decodes legal with RegWrite=1, and an extra port ex_muldiv (out, 1) is registered with the same load/stall/flush rules.
- Undefined: those encodings are illegal and the port is absent.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants OP_LOAD, OP_IMM, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM;
  - bit-index localparams for the 15-bit ex_ctrl bundle and its width CTRL_W=15.
- One sub-module, ctrl_decode_comb: pure combinational opcode/funct → {ctrl, illegal}. The top holds the ID/EX registers, ie and halt.

Test Plan:
- Apply lw (0x00, 00010) with id_valid=1 → next cycle ex_valid=1 and MemToReg=ALU_SRC=RegWrite=1, other bits 0. lbu (00100) additionally sets LBU.
- Apply STI (0x1C, 00110) → ie 0→1 one cycle later. Apply CLI (00111) with flush=1 → ie stays 1. Apply CLI with flush=0 → ie=0.
- Apply SUB (0x0C, 10000), then hold stall=1 for 3 cycles while presenting ADD → ex_ctrl stays SUB (RegWrite only) and ex_valid stays 1.
- Assert stall=1 and flush=1 together → ex_valid=0, ex_ctrl=0 next cycle.
- Apply ecall (0x1C, 00000) → ex_ecall bit=1 for one cycle, halt=1 and id_ready=0 afterwards. Following lw gives ex_valid=0. Pulse rst → halt=0, ie=IE_RESET.
- Apply illegal SLLI with f=10001, or opcode 0x1F → ex_illegal=1, ex_valid=0, ex_ctrl=0. With RV32M_EN, apply f=01000 on 0x0C → ex_muldiv=1 and RegWrite=1.
